iir_mac_sequencer: RTL



---
 rtl/iir_mac_sequencer_if.sv | 40 ++++
 rtl/iir_mac_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/iir_mac_sequencer_if.sv
// Control bundle between the IIR MAC sequencer (master) and the shared datapath (slave).
// IIR_SEQ_EXT_TICK_EN adds the ext_tick input used instead of the internal divider.
interface iir_mac_sequencer_if #(
    parameter int CAW = 4
);
    logic           en;
`ifdef IIR_SEQ_EXT_TICK_EN
    logic           ext_tick;
`endif
    logic           sample_tick;
    logic           in_we;
    logic [CAW-1:0] coef_addr;
    logic [2:0]     sec_idx;
    logic [2:0]     tap_idx;
    logic           acc_clr;
    logic           acc_en;
    logic           mul_sub;
    logic           state_we;
    logic           out_we;
    logic           busy;
    logic           overrun;

    modport master (
        input  en,
`ifdef IIR_SEQ_EXT_TICK_EN
        input  ext_tick,
`endif
        output sample_tick, in_we, coef_addr, sec_idx, tap_idx,
        output acc_clr, acc_en, mul_sub, state_we, out_we, busy, overrun
    );

    modport slave (
        output en,
`ifdef IIR_SEQ_EXT_TICK_EN
        output ext_tick,
`endif
        input  sample_tick, in_we, coef_addr, sec_idx, tap_idx,
        input  acc_clr, acc_en, mul_sub, state_we, out_we, busy, overrun
    );
endinterface

// File: rtl/iir_mac_sequencer.sv
// Sample-rate strobe and per-tap control sequencer for a time-shared cascade of biquads.
// Define IIR_SEQ_EXT_TICK_EN to take the sample strobe from ext_tick instead of the divider.
module iir_mac_sequencer #(
    parameter int SAMPLE_DIV = 800,
    parameter int NSEC       = 2,
    parameter int CAW        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    iir_mac_sequencer_if.master  bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_MAC  = 3'd2;
    localparam logic [2:0] ST_WB   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int AW = (CAW > 6) ? CAW : 6;

    logic [2:0]    state;
    logic [2:0]    sec;
    logic [2:0]    tap;
    logic [2:0]    nxt_state;
    logic [2:0]    nxt_sec;
    logic [2:0]    nxt_tap;
    logic [AW-1:0] nxt_addr;
    logic          nxt_mac;

`ifdef IIR_SEQ_EXT_TICK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.sample_tick <= 1'b0;
        end else begin
            bus.sample_tick <= bus.ext_tick & bus.en;
        end
    end
`else
    localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

    logic [CW-1:0] div_cnt;

    // The tick is registered one count early so it is high exactly while div_cnt is at its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt         <= '0;
            bus.sample_tick <= 1'b0;
        end else if (bus.en) begin
            div_cnt         <= (div_cnt == CW'(SAMPLE_DIV - 1)) ? '0 : div_cnt + CW'(1);
            bus.sample_tick <= (div_cnt == CW'(SAMPLE_DIV - 2));
        end else begin
            div_cnt         <= '0;
            bus.sample_tick <= 1'b0;
        end
    end
`endif

    always_comb begin
        nxt_state = state;
        nxt_sec   = sec;
        nxt_tap   = tap;
        case (state)
            ST_IDLE: begin
                if (bus.sample_tick) begin
                    nxt_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                nxt_state = ST_MAC;
                nxt_sec   = 3'd0;
                nxt_tap   = 3'd0;
            end
            ST_MAC: begin
                if (tap == 3'd4) begin
                    nxt_state = ST_WB;
                end else begin
                    nxt_tap = tap + 3'd1;
                end
            end
            ST_WB: begin
                if (sec == 3'(NSEC - 1)) begin
                    nxt_state = ST_DONE;
                end else begin
                    nxt_state = ST_MAC;
                    nxt_sec   = sec + 3'd1;
                    nxt_tap   = 3'd0;
                end
            end
            ST_DONE: begin
                nxt_state = ST_IDLE;
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
    end

    assign nxt_mac  = (nxt_state == ST_MAC);
    assign nxt_addr = AW'(nxt_sec) * AW'(5) + AW'(nxt_tap);

    // Outputs are decoded from the next state so every control line is a flop aligned with its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            sec           <= 3'd0;
            tap           <= 3'd0;
            bus.in_we     <= 1'b0;
            bus.coef_addr <= '0;
            bus.sec_idx   <= 3'd0;
            bus.tap_idx   <= 3'd0;
            bus.acc_clr   <= 1'b0;
            bus.acc_en    <= 1'b0;
            bus.mul_sub   <= 1'b0;
            bus.state_we  <= 1'b0;
            bus.out_we    <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= nxt_state;
            sec           <= nxt_sec;
            tap           <= nxt_tap;
            bus.in_we     <= (nxt_state == ST_LOAD);
            bus.coef_addr <= nxt_mac ? nxt_addr[CAW-1:0] : '0;
            bus.sec_idx   <= (nxt_mac || nxt_state == ST_WB) ? nxt_sec : 3'd0;
            bus.tap_idx   <= nxt_mac ? nxt_tap : 3'd0;
            bus.acc_clr   <= nxt_mac && (nxt_tap == 3'd0);
            bus.acc_en    <= nxt_mac;
            bus.mul_sub   <= nxt_mac && (nxt_tap >= 3'd3);
            bus.state_we  <= (nxt_state == ST_WB);
            bus.out_we    <= (nxt_state == ST_DONE);
            bus.busy      <= (nxt_state != ST_IDLE);
        end
    end

    // A tick during DONE is still dropped: busy is high in that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.overrun <= 1'b0;
        end else if (bus.sample_tick && bus.busy) begin
            bus.overrun <= 1'b1;
        end
    end
endmodule
